// File: rtl/keymgr_cfg_en_pkg.sv
// Shared types and constants for the key manager configuration-enable bank.
// Optional shadow protection is selected with `KEYMGR_CFG_EN_SHADOW_EN.
package keymgr_cfg_en_pkg;

  localparam int unsigned MaxCh = 16;

  // Pairwise Hamming distance of at least two, so a single bit flip never
  // lands on another legal state.
  typedef enum logic [3:0] {
    StReset    = 4'b0011,
    StOpen     = 4'b0101,
    StClosed   = 4'b1001,
    StDisabled = 4'b1110
  } cfg_en_st_e;

  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/keymgr_cfg_en_ch.sv
// One channel of the configuration-enable bank: state machine, auto-close timer
// and, with `KEYMGR_CFG_EN_SHADOW_EN, an inverted shadow copy with mismatch detect.
module keymgr_cfg_en_ch
  import keymgr_cfg_en_pkg::*;
#(
  parameter int unsigned TimeoutCyc = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic init,
  input  logic set,
  input  logic clr,
  output logic open,
  output logic armed,
  output logic mismatch
);

  localparam int unsigned CntW = cnt_width(TimeoutCyc);
  localparam logic [CntW-1:0] CntLast = (TimeoutCyc > 0) ? CntW'(TimeoutCyc - 1) : '0;
  localparam logic [CntW-1:0] CntMax  = '1;

  cfg_en_st_e      st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= StReset;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // The counter only survives undisturbed Open cycles; every other path clears it.
  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    case (st_q)
      StReset: begin
        if (init) st_d = StOpen;
      end
      StDisabled: begin
        if (init) st_d = StClosed;
      end
      StOpen, StClosed: begin
        if (!en) begin
          st_d = StDisabled;
        end else if (set) begin
          st_d = StOpen;
        end else if (clr) begin
          st_d = StClosed;
        end else if (st_q == StOpen && TimeoutCyc > 0) begin
          if (cnt_q == CntLast) begin
            st_d = StClosed;
          end else begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        st_d = StDisabled;
      end
    endcase
  end

  always_comb begin
    open  = 1'b0;
    armed = 1'b0;
    case (st_q)
      StReset:  open = 1'b1;
      StOpen: begin
        open  = 1'b1;
        armed = 1'b1;
      end
      StClosed: armed = 1'b1;
      default: begin
        open  = 1'b0;
        armed = 1'b0;
      end
    endcase
  end

`ifdef KEYMGR_CFG_EN_SHADOW_EN
  logic [3:0]      st_shadow_q;
  logic [CntW-1:0] cnt_shadow_q;
  logic            st_legal;

  // The shadow holds the bit-inverted image so stuck-at faults show as mismatch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_shadow_q  <= ~StReset;
      cnt_shadow_q <= '1;
    end else begin
      st_shadow_q  <= ~st_d;
      cnt_shadow_q <= ~cnt_d;
    end
  end

  always_comb begin
    st_legal = st_q inside {StReset, StOpen, StClosed, StDisabled};
    mismatch = (st_q != ~st_shadow_q) | (cnt_q != ~cnt_shadow_q) | ~st_legal;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: rtl/keymgr_cfg_en_bank.sv
// Multi-channel shadowed configuration-enable bank for the key manager.
// Define `KEYMGR_CFG_EN_SHADOW_EN to enable the shadow copies and sticky fault_o.
module keymgr_cfg_en_bank
  import keymgr_cfg_en_pkg::*;
#(
  parameter int unsigned NumCh      = 4,
  parameter bit          NonInitClr = 1'b1,
  parameter int unsigned TimeoutCyc = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [NumCh-1:0] init_i,
  input  logic [NumCh-1:0] set_i,
  input  logic [NumCh-1:0] clr_i,
  output logic [NumCh-1:0] out_o,
  output logic             fault_o
);

  logic [NumCh-1:0] open;
  logic [NumCh-1:0] armed;
  logic [NumCh-1:0] mismatch;
  logic [NumCh-1:0] clr_mask;

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    keymgr_cfg_en_ch #(
      .TimeoutCyc(TimeoutCyc)
    ) u_ch (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .en      (en_i),
      .init    (init_i[i]),
      .set     (set_i[i]),
      .clr     (clr_i[i]),
      .open    (open[i]),
      .armed   (armed[i]),
      .mismatch(mismatch[i])
    );
  end

  // With NonInitClr cleared, a clear request cannot hide a channel that was never armed.
  assign clr_mask = NonInitClr ? clr_i : (armed & clr_i);

`ifdef KEYMGR_CFG_EN_SHADOW_EN
  logic fault_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
    end else if (|mismatch) begin
      fault_q <= 1'b1;
    end
  end

  assign fault_o = fault_q;
  assign out_o   = open & {NumCh{en_i}} & ~clr_mask & {NumCh{~fault_q}};
`else
  logic unused_mismatch;

  assign unused_mismatch = |mismatch;
  assign fault_o         = 1'b0;
  assign out_o           = open & {NumCh{en_i}} & ~clr_mask;
`endif

endmodule

// File: tb/tb_keymgr_cfg_en_bank.sv
// Self-checking bench for keymgr_cfg_en_bank: two instances (timeout/NonInitClr=1 and
// no-timeout/NonInitClr=0) checked every cycle against an armed/open/time-left model.
module tb_keymgr_cfg_en_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] init = '0;
  logic [3:0] set = '0;
  logic [3:0] clr = '0;
  logic [3:0] out_a, out_b;
  logic       fault_a, fault_b;

  int assert_count = 0;
  int fail_count = 0;
  bit check_en = 1'b0;
  bit inj_a = 1'b0;

  // Instance 0: NonInitClr=1, TimeoutCyc=5. Instance 1: NonInitClr=0, TimeoutCyc=0.
  int unsigned tcyc [2] = '{5, 0};
  bit          nic  [2] = '{1'b1, 1'b0};
  bit          m_armed [2][4];
  bit          m_open  [2][4];
  int          m_left  [2][4];
  bit          m_fault [2];

  always #5 clk = ~clk;

  keymgr_cfg_en_bank #(.NumCh(4), .NonInitClr(1'b1), .TimeoutCyc(5)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .init_i(init), .set_i(set), .clr_i(clr),
    .out_o(out_a), .fault_o(fault_a)
  );

  keymgr_cfg_en_bank #(.NumCh(4), .NonInitClr(1'b0), .TimeoutCyc(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .init_i(init), .set_i(set), .clr_i(clr),
    .out_o(out_b), .fault_o(fault_b)
  );

  // Model: each channel is an (armed, open) pair plus cycles left before auto-close.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_fault[d] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          m_armed[d][c] = 1'b0;
          m_open[d][c]  = 1'b1;
          m_left[d][c]  = 0;
        end
      end else begin
        if (d == 0 && inj_a) m_fault[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
          if (!m_armed[d][c]) begin
            if (init[c]) begin
              m_armed[d][c] = 1'b1;
              m_left[d][c]  = int'(tcyc[d]);
            end
          end else if (!en) begin
            m_armed[d][c] = 1'b0;
            m_open[d][c]  = 1'b0;
          end else if (set[c]) begin
            m_open[d][c] = 1'b1;
            m_left[d][c] = int'(tcyc[d]);
          end else if (clr[c]) begin
            m_open[d][c] = 1'b0;
          end else if (m_open[d][c] && tcyc[d] > 0) begin
            m_left[d][c] = m_left[d][c] - 1;
            if (m_left[d][c] == 0) m_open[d][c] = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [3:0] model_out(input int d);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) begin
      r[c] = m_open[d][c] & en & ~(nic[d] ? clr[c] : (m_armed[d][c] & clr[c])) & ~m_fault[d];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] i,
                               input logic [3:0] s, input logic [3:0] c);
    @(posedge clk);
    #1;
    rst_n = r;
    en    = e;
    init  = i;
    set   = s;
    clr   = c;
    inj_a = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_out_a", out_a, model_out(0));
      checkOutput("model_out_b", out_b, model_out(1));
      checkOutput("model_fault_a", {3'b000, fault_a}, {3'b000, m_fault[0]});
      checkOutput("model_fault_b", {3'b000, fault_b}, {3'b000, m_fault[1]});
    end
  end

`ifdef KEYMGR_CFG_EN_SHADOW_EN
  logic [3:0] shadow_val;
`endif

  initial begin
    @(posedge clk);
    #1;
    check_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("reset_out_a", out_a, 4'b1111);
    checkOutput("reset_out_b", out_b, 4'b1111);
    checkOutput("reset_fault_a", {3'b000, fault_a}, 4'b0000);

    // Arm channel 0, close it, then reopen it.
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001);
    @(negedge clk);
    checkOutput("clr_cycle_a", out_a, 4'b1110);
    checkOutput("clr_cycle_b", out_b, 4'b1110);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("closed_a", out_a, 4'b1110);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000);
    @(negedge clk);
    checkOutput("set_same_cycle_a", out_a, 4'b1110);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("reopen_a", out_a, 4'b1111);

    // Global disable drops every armed channel for good.
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("en_low_a", out_a, 4'b0000);
    checkOutput("en_low_b", out_b, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("disabled_a", out_a, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("rearm_closed_a", out_a, 4'b0000);
    checkOutput("rearm_closed_b", out_b, 4'b0000);

    // Mid-operation reset restores every channel.
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("midreset_out_a", out_a, 4'b1111);

    // Undisturbed timeout: exactly five open cycles on the timed instance.
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000);
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput($sformatf("timeout_c%0d", c), {3'b000, out_a[1]}, (c <= 5) ? 4'd1 : 4'd0);
    end
    checkOutput("no_timeout_b", {3'b000, out_b[1]}, 4'd1);

    // A set in open cycle 3 restarts the five-cycle window.
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000);
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1'b1, 1'b1, 4'b0000, (c == 3) ? 4'b0010 : 4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput($sformatf("extend_c%0d", c), {3'b000, out_a[1]}, (c <= 8) ? 4'd1 : 4'd0);
    end

    // Clear on an unarmed channel only masks when NonInitClr is set.
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0100);
    @(negedge clk);
    checkOutput("noninit_clr_a", out_a, 4'b1011);
    checkOutput("noninit_clr_b", out_b, 4'b1111);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("after_clr_b", out_b, 4'b1111);

    // Simultaneous set and clear: masked now, open afterwards.
    applyStimulus(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1000);
    @(negedge clk);
    checkOutput("set_clr_a", out_a, 4'b0111);
    checkOutput("set_clr_b", out_b, 4'b0111);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("set_wins_b", out_b, 4'b1111);

`ifdef KEYMGR_CFG_EN_SHADOW_EN
    // Flip one shadow bit of channel 3 for a single cycle.
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    shadow_val = dut_a.g_ch[3].u_ch.st_shadow_q;
    force dut_a.g_ch[3].u_ch.st_shadow_q = shadow_val ^ 4'b0001;
    inj_a = 1'b1;
    @(negedge clk);
    release dut_a.g_ch[3].u_ch.st_shadow_q;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput("fault_out_a", out_a, 4'b0000);
      checkOutput("fault_hold_a", {3'b000, fault_a}, 4'd1);
    end
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("fault_cleared_a", {3'b000, fault_a}, 4'd0);
`endif

    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
